// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared constants and stage record for the sliced,
//                pipelined 32-bit subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Datapath geometry: one pipeline stage per slice.
    localparam int DATA_W     = 32;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = DATA_W / SLICE_W;

    // Everything a stage carries forward. Resolved difference bits accumulate
    // in diff from the bottom up, while rem_a/rem_b shift down one slice per
    // stage so the operands of the next slice always sit in the low bits.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] diff;
        logic              borrow;
        logic [DATA_W-1:0] rem_a;
        logic [DATA_W-1:0] rem_b;
    } stage_t;

    // Source record presented to stage 0: nothing resolved yet, no borrow in.
    function automatic stage_t stage_from_inputs(
        input logic              valid,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        stage_t s;
        s        = '0;
        s.valid  = valid;
        s.rem_a  = a;
        s.rem_b  = b;
        return s;
    endfunction

endpackage : sub_pkg
`default_nettype wire

// File: rtl/subtractor_8bit_slice.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_8bit_slice
//  Description : Combinational 8-bit subtract cell with borrow in/out;
//                counterpart of the 8-bit adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor_8bit_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic [7:0] diff,
    output logic       bout
);

    logic [8:0] w_wide;

    // A 9-bit subtraction: the ninth bit goes high exactly when a < b + bin,
    // which is the borrow out of this slice.
    always_comb begin
        w_wide = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        diff   = w_wide[7:0];
        bout   = w_wide[8];
    end

endmodule : subtractor_8bit_slice
`default_nettype wire

// File: rtl/subtractor_32bit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_32bit_pipe
//  Description : diff = a - b (mod 2^WIDTH) with borrow out, resolved one
//                8-bit slice per pipeline stage, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor_32bit_pipe #(
    // Must agree with the geometry in sub_pkg (the stage record is sized there).
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    import sub_pkg::*;

    localparam int LAST = NUM_SLICES - 1;

    // Stage registers and the combinational view feeding each of them.
    stage_t r_stage [NUM_SLICES];
    stage_t w_src   [NUM_SLICES];
    stage_t w_next  [NUM_SLICES];

    // w_ready[k] says stage k may load this cycle; the top entry is out_ready.
    logic [NUM_SLICES:0]  w_ready;

    logic [SLICE_W-1:0]   w_slice_diff [NUM_SLICES];
    logic [NUM_SLICES-1:0] w_slice_bout;

    // Each stage consumes the record of the stage before it; stage 0 consumes
    // the input port with an empty partial result and zero borrow.
    always_comb begin
        w_src[0] = stage_from_inputs(in_valid, a, b);
        for (int k = 1; k < NUM_SLICES; k++) begin
            w_src[k] = r_stage[k-1];
        end
    end

    // One subtract cell per stage, always working on the lowest remaining slice.
    generate
        for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
            subtractor_8bit_slice u_slice (
                .a    (w_src[k].rem_a[SLICE_W-1:0]),
                .b    (w_src[k].rem_b[SLICE_W-1:0]),
                .bin  (w_src[k].borrow),
                .diff (w_slice_diff[k]),
                .bout (w_slice_bout[k])
            );
        end
    endgenerate

    // Build the record each stage would capture: splice the new slice into the
    // partial difference, forward the slice borrow, shift the operands down.
    always_comb begin
        for (int k = 0; k < NUM_SLICES; k++) begin
            w_next[k]                             = w_src[k];
            w_next[k].diff[k*SLICE_W +: SLICE_W]  = w_slice_diff[k];
            w_next[k].borrow                      = w_slice_bout[k];
            w_next[k].rem_a                       = w_src[k].rem_a >> SLICE_W;
            w_next[k].rem_b                       = w_src[k].rem_b >> SLICE_W;
        end
    end

    // Ready ripples back from the output: an empty stage, or one whose
    // successor will take its contents, can accept new data. This lets
    // bubbles collapse forward while the output is stalled.
    always_comb begin
        w_ready[NUM_SLICES] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            w_ready[k] = !r_stage[k].valid || w_ready[k+1];
        end
    end

    // Stage registers: load when ready, otherwise hold; reset clears data too
    // so nothing undefined ever reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SLICES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SLICES; k++) begin
                if (w_ready[k]) begin
                    r_stage[k] <= w_next[k];
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_stage[LAST].valid;
    assign diff      = r_stage[LAST].diff;
    assign borrow    = r_stage[LAST].borrow;

endmodule : subtractor_32bit_pipe
`default_nettype wire

// File: tb/tb_subtractor_32bit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subtractor_32bit_pipe
//  Description : Directed-vector bench for the pipelined 32-bit subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_32bit_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_b;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   run      = 0;
    int   max_run  = 0;
    bit   prev_stall = 1'b0;
    logic [31:0] held_d;
    logic        held_b;

    subtractor_32bit_pipe #(.WIDTH(32), .SLICE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: every retiring result must match the oldest outstanding
    // expectation; a stalled result must not change while it waits.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            run        = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got diff=%h borrow=%b with nothing outstanding", diff, borrow);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (diff !== e.d || borrow !== e.b) begin
                        n_fail++;
                        $display("FAIL result: got diff=%h borrow=%b expected diff=%h borrow=%b",
                                 diff, borrow, e.d, e.b);
                    end
                end
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    n_checks++;
                    if (diff !== held_d || borrow !== held_b) begin
                        n_fail++;
                        $display("FAIL hold: got diff=%h borrow=%b expected diff=%h borrow=%b",
                                 diff, borrow, held_d, held_b);
                    end
                end
                held_d     = diff;
                held_b     = borrow;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Present one pair, wait (bounded) for acceptance, record the expectation.
    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, output int stalls);
        exp_t e;
        stalls   = 0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
                break;
            end
        end
        if (stalls <= 200) begin
            e.d = ed;
            e.b = eb;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check1(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        int          st;
        int          edges;
        int          accepted;
        int          seen;
        int          total_stalls;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] wide;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0};
        vecs[1] = '{32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
        vecs[8] = '{32'h0001_0000, 32'h0000_0100, 32'h0000_FF00, 1'b0};
        vecs[9] = '{32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check1("reset_out_valid", 32'(out_valid), 32'd0);
        check1("reset_in_ready",  32'(in_ready),  32'd1);
        check1("reset_diff",      diff,           32'd0);
        check1("reset_borrow",    32'(borrow),    32'd0);

        // Latency of a single transaction with no backpressure
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 32'h0000_0005;
        b        = 32'h0000_0003;
        @(negedge clk);
        check1("latency_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back('{32'h0000_0002, 1'b0});
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) break;
        end
        check1("latency_edges", 32'(edges), 32'd4);
        wait_drain("latency_drain");

        // Directed table, back to back
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_b, st);
        end
        wait_drain("table_drain");

        // Streaming: 16 random pairs at full rate
        max_run      = 0;
        total_stalls = 0;
        for (int i = 0; i < 16; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            wide = {1'b0, ra} - {1'b0, rb};
            send(ra, rb, wide[31:0], wide[32], st);
            total_stalls += st;
        end
        check1("stream_stalls", 32'(total_stalls), 32'd0);
        wait_drain("stream_drain");
        check1("stream_consecutive", 32'(max_run), 32'd16);

        // Backpressure: exactly four accepts fill the pipe, then drain in order
        out_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 10; c++) begin
            ra       = 32'h1000_0000 + 32'(accepted) * 32'h0101_1111;
            rb       = 32'h0000_0F0F * 32'(accepted + 1) + 32'h2000_0000 * 32'(accepted & 1);
            a        = ra;
            b        = rb;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                wide = {1'b0, ra} - {1'b0, rb};
                exp_q.push_back('{wide[31:0], wide[32]});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check1("bp_accepts", 32'(accepted), 32'd4);
        @(negedge clk);
        check1("bp_in_ready_low", 32'(in_ready), 32'd0);
        check1("bp_out_valid",    32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("bp_drain");

        // Reset mid-flight discards in-flight work
        send(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, st);
        send(32'h0000_0020, 32'h0000_0002, 32'h0000_001E, 1'b0, st);
        send(32'h0000_0030, 32'h0000_0003, 32'h0000_002D, 1'b0, st);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("midreset_out_valid", 32'(out_valid), 32'd0);
        check1("midreset_in_ready",  32'(in_ready),  32'd1);
        check1("midreset_diff",      diff,           32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check1("midreset_no_ghosts", 32'(seen), 32'd0);

        // Recovery after reset
        @(posedge clk);
        #1;
        send(vecs[9].a, vecs[9].b, vecs[9].exp_d, vecs[9].exp_b, st);
        wait_drain("recover_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule : tb_subtractor_32bit_pipe
`default_nettype wire
